// File: rtl/prod_accum_pkg.sv
// Shared types and defaults for the product accumulator.
// Optional saturation is selected with the PROD_ACCUM_SAT_EN macro.
package prod_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
  localparam int CNT_W       = 8;
  localparam int N_TERMS_DEF = 4;
  localparam int SUM_W_DEF   = 20;
endpackage

// File: rtl/prod_accum_add.sv
// Registered accumulator: clear, or add a 16-bit unsigned term when enabled.
// PROD_ACCUM_SAT_EN selects a saturating add with a sticky overflow flag.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [15:0]      din,
  output logic [SUM_W-1:0] acc_o
`ifdef PROD_ACCUM_SAT_EN
  ,
  output logic             ovf_o
`endif
);
  logic [SUM_W-1:0] acc_q, acc_d;

`ifdef PROD_ACCUM_SAT_EN
  logic             ovf_q, ovf_d;
  logic [SUM_W:0]   sum_w;

  // One extra bit catches the carry that triggers saturation.
  assign sum_w = {1'b0, acc_q} + (SUM_W+1)'(din);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      if (sum_w[SUM_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_w[SUM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic [SUM_W-1:0] sum_w;

  assign sum_w = acc_q + SUM_W'(din);

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum_w;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/prod_accum.sv
// Drains N_TERMS products from the multiply FIFO, sums them and offers the sum on valid/ready.
// Build with PROD_ACCUM_SAT_EN for a saturating sum and the OVF port.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int SUM_W   = SUM_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [15:0]      DIN,
  input  logic             EMPTY,
  input  logic             VALID,
  output logic             RD,
  output logic [SUM_W-1:0] SUM,
  output logic             SUM_VALID,
  input  logic             SUM_READY,
  output logic [CNT_W-1:0] BLK_CNT
`ifdef PROD_ACCUM_SAT_EN
  ,
  output logic             OVF
`endif
);
  localparam logic [CNT_W-1:0] NT = CNT_W'(N_TERMS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, recv_q, recv_d, blk_q, blk_d;
  logic [SUM_W-1:0] hold_q, hold_d, acc;
  logic             take, accept;

  assign RD     = (state_q == ACC) & ENABLE & ~EMPTY & (issued_q < NT);
  // Only data we actually asked for counts; strays after a reset fall out here.
  assign take   = (state_q == ACC) & VALID & (recv_q < issued_q);
  assign accept = (state_q == DONE) & SUM_READY;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q + CNT_W'(RD);
    recv_d   = recv_q + CNT_W'(take);
    blk_d    = blk_q;
    hold_d   = hold_q;
    case (state_q)
      IDLE:    if (ENABLE) state_d = ACC;
      ACC:     if (take && recv_q == NT - 1'b1) state_d = DONE;
      DONE:    if (accept) state_d = ACC;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      issued_d = '0;
      recv_d   = '0;
      blk_d    = blk_q + 1'b1;
      hold_d   = acc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      issued_q <= '0;
      recv_q   <= '0;
      blk_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      blk_q    <= blk_d;
      hold_q   <= hold_d;
    end
  end

  prod_accum_add #(.SUM_W(SUM_W)) u_add (
    .clk   (CLK),
    .rst   (RST),
    .clr   (accept),
    .en    (take),
    .din   (DIN),
    .acc_o (acc)
`ifdef PROD_ACCUM_SAT_EN
    ,
    .ovf_o (OVF)
`endif
  );

  assign SUM       = (state_q == DONE) ? acc : hold_q;
  assign SUM_VALID = (state_q == DONE);
  assign BLK_CNT   = blk_q;
endmodule
